amiga_clk_phase_tracker: RTL and testbench

//  Oversamples the Amiga quadrature bus clocks C7M/CDAC (90 deg apart) on a fast CLK.

---
 rtl/amiga_clk_pkg.sv | 30 +++
 rtl/sync_ff.sv | 30 +++
 rtl/amiga_clk_phase_tracker.sv | 188 ++++++++++++++++++
 tb/tb_amiga_clk_phase_tracker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amiga_clk_pkg.sv
// Shared encodings and helpers for the Amiga C7M/CDAC quadrature phase tracker.
package amiga_clk_pkg;

    // {C7M,CDAC} state for each quarter-phase, in forward order.
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    // Expected next {C7M,CDAC} state when the bus clocks run forward.
    function automatic logic [1:0] gray_next(input logic [1:0] state);
        case (state)
            PH0:     gray_next = PH1;
            PH1:     gray_next = PH2;
            PH2:     gray_next = PH3;
            default: gray_next = PH0;
        endcase
    endfunction

    // Quarter-phase index 0..3 of a {C7M,CDAC} state.
    function automatic logic [1:0] phase_idx(input logic [1:0] state);
        case (state)
            PH0:     phase_idx = 2'd0;
            PH1:     phase_idx = 2'd1;
            PH2:     phase_idx = 2'd2;
            default: phase_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Reset-to-zero multi-flop synchronizer for one asynchronous input bit.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at the LSB; the MSB is the settled output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchronizer chain, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/amiga_clk_phase_tracker.sv
// Tracks the C7M/CDAC quarter-phase on a fast clock, measures the quarter period,
// declares lock, and regenerates C14M plus an interpolated C28M and predictive strobes.
module amiga_clk_phase_tracker
    import amiga_clk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned TOL         = 2,
    parameter int unsigned ADVANCE     = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             C7M,
    input  logic             CDAC,
    output logic             C14M_OUT,
    output logic             C28M_OUT,
    output logic [1:0]       PHASE,
    output logic [3:0]       EDGE_STB,
    output logic             PRE_STB,
    output logic             LOCKED,
    output logic             ERR_STB,
    output logic [CNT_W-1:0] QPER
);

    localparam int unsigned      CW1     = CNT_W + 1;
    localparam int unsigned      LCW     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CW1-1:0]   TOL_C   = CW1'(TOL);
    localparam logic [CW1-1:0]   ADV_C   = CW1'(ADVANCE);
    localparam logic [LCW-1:0]   LOCK_C  = LCW'(LOCK_COUNT);

    logic [1:0] sync_st;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_c7m (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (C7M),
        .q_o   (sync_st[1])
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cdac (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (CDAC),
        .q_o   (sync_st[0])
    );

    logic             armed_q, armed_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    logic [CNT_W-1:0] qper_q, qper_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [1:0]       seen_q, seen_d;
    logic             locked_q, locked_d;
    logic [3:0]       edge_q, edge_d;
    logic             err_q, err_d;
    logic             c14_q, c14_d;
    logic             c28_q, c28_d;
    logic             pre_q, pre_d;

    logic             step, valid_step, illegal_step, match;
    logic [CW1-1:0]   inc, qper_ext, diff;

    // Step classification and the tolerance test of the just-finished quarter.
    always_comb begin
        step         = armed_q && (sync_st != prev_q);
        valid_step   = step && (gray_next(prev_q) == sync_st);
        illegal_step = step && !valid_step;
        inc          = {1'b0, qcnt_q} + CW1'(1);
        qper_ext     = {1'b0, qper_q};
        diff         = (inc >= qper_ext) ? (inc - qper_ext) : (qper_ext - inc);
        // The first quarter after reset is partial and the second compares against it.
        match        = (seen_q == 2'd2) && (diff <= TOL_C);
    end

    // Next-state: phase tracking, period measurement, lock and strobe generation.
    always_comb begin
        armed_d    = 1'b1;
        prev_d     = prev_q;
        phase_d    = phase_q;
        qper_d     = qper_q;
        lock_cnt_d = lock_cnt_q;
        seen_d     = seen_q;
        locked_d   = locked_q;
        edge_d     = '0;
        err_d      = 1'b0;
        c14_d      = sync_st[1] ^ sync_st[0];
        qcnt_d     = (qcnt_q == CNT_MAX) ? qcnt_q : qcnt_q + CNT_W'(1);

        if (!armed_q) begin
            prev_d  = sync_st;
            phase_d = phase_idx(sync_st);
        end else if (valid_step) begin
            prev_d  = sync_st;
            phase_d = phase_idx(sync_st);
            edge_d  = 4'b0001 << phase_idx(sync_st);
            qcnt_d  = '0;
            qper_d  = inc[CNT_W] ? CNT_MAX : inc[CNT_W-1:0];
            if (seen_q != 2'd2) begin
                seen_d = seen_q + 2'd1;
            end
            if (match) begin
                if (lock_cnt_q != LOCK_C) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
                if (lock_cnt_d == LOCK_C) begin
                    locked_d = 1'b1;
                end
            end else begin
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end else if (illegal_step) begin
            prev_d     = sync_st;
            phase_d    = phase_idx(sync_st);
            qcnt_d     = '0;
            err_d      = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (qcnt_d == CNT_MAX) begin
            // Quarter counter saturated: bus clock has stopped.
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end

        // C28M rises with each step and falls mid-quarter.
        if (!locked_d) begin
            c28_d = 1'b0;
        end else if (valid_step) begin
            c28_d = 1'b1;
        end else if (qcnt_d == (qper_d >> 1)) begin
            c28_d = 1'b0;
        end else begin
            c28_d = c28_q;
        end

        pre_d = 1'b0;
        if ((ADVANCE > 0) && locked_d && ({1'b0, qper_d} > ADV_C) &&
            (({1'b0, qcnt_d} + ADV_C) == ({1'b0, qper_d} - CW1'(1)))) begin
            pre_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            armed_q    <= 1'b0;
            prev_q     <= '0;
            phase_q    <= '0;
            qcnt_q     <= '0;
            qper_q     <= '0;
            lock_cnt_q <= '0;
            seen_q     <= '0;
            locked_q   <= 1'b0;
            edge_q     <= '0;
            err_q      <= 1'b0;
            c14_q      <= 1'b0;
            c28_q      <= 1'b0;
            pre_q      <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            prev_q     <= prev_d;
            phase_q    <= phase_d;
            qcnt_q     <= qcnt_d;
            qper_q     <= qper_d;
            lock_cnt_q <= lock_cnt_d;
            seen_q     <= seen_d;
            locked_q   <= locked_d;
            edge_q     <= edge_d;
            err_q      <= err_d;
            c14_q      <= c14_d;
            c28_q      <= c28_d;
            pre_q      <= pre_d;
        end
    end

    assign C14M_OUT = c14_q;
    assign C28M_OUT = c28_q;
    assign PHASE    = phase_q;
    assign EDGE_STB = edge_q;
    assign PRE_STB  = pre_q;
    assign LOCKED   = locked_q;
    assign ERR_STB  = err_q;
    assign QPER     = qper_q;

endmodule

// File: tb/tb_amiga_clk_phase_tracker.sv
// Bench for amiga_clk_phase_tracker: table-driven nominal stream, hand-written corner
// sequences and randomized quadrature streams, all checked every cycle against a
// timestamp-based reference model.
`timescale 1ns/100ps
module tb_amiga_clk_phase_tracker;

    localparam int MAXN = 8192;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       C7M = 1'b0;
    logic       CDAC = 1'b0;
    logic       C14M_OUT, C28M_OUT, PRE_STB, LOCKED, ERR_STB;
    logic [1:0] PHASE;
    logic [3:0] EDGE_STB;
    logic [7:0] QPER;

    always #2.5 CLK = ~CLK;

    amiga_clk_phase_tracker #(
        .SYNC_STAGES (2),
        .CNT_W       (8),
        .LOCK_COUNT  (8),
        .TOL         (2),
        .ADVANCE     (2)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .C7M      (C7M),
        .CDAC     (CDAC),
        .C14M_OUT (C14M_OUT),
        .C28M_OUT (C28M_OUT),
        .PHASE    (PHASE),
        .EDGE_STB (EDGE_STB),
        .PRE_STB  (PRE_STB),
        .LOCKED   (LOCKED),
        .ERR_STB  (ERR_STB),
        .QPER     (QPER)
    );

    int checks = 0;
    int failures = 0;

    // Driven history: drv[j]/rstv[j] set at negedge j, seen by the DUT at posedge j+1.
    logic [1:0] drv  [0:MAXN-1];
    logic       rstv [0:MAXN-1];
    int         n = 4;
    int         rst_edge = 0;

    // Reference model state (timestamps in posedge indices).
    int m_qper = 0, m_tlast = 0, m_run = 0, m_nsteps = 0;
    bit m_locked = 0, m_c28 = 0;

    // Last observed outputs.
    logic [3:0] o_edge;
    logic       o_locked, o_err, o_pre, o_c28;
    logic [7:0] o_qper;

    typedef struct {
        logic [1:0] st;
        int         hold;
        logic [3:0] exp_edge;
        logic       exp_locked;
        logic [1:0] exp_phase;
    } vec_t;

    function automatic int pidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] pnext(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] eff(input int j);
        return (j < rst_edge) ? 2'b00 : drv[j];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, n, act, exp);
        end
    endtask

    // Advance the model to posedge n and compare every output.
    task automatic model_step();
        logic [1:0] cur, prv;
        int         qraw, qcnt, meas, dq;
        bit         vstep, istep, e_err, e_pre, e_c14;
        logic [3:0] e_edge;
        int         e_phase;
        e_edge = '0; e_err = 0; e_pre = 0; e_c14 = 0; e_phase = 0; qcnt = 0;
        if (rstv[n-1]) begin
            rst_edge = n; m_tlast = n; m_qper = 0; m_run = 0; m_nsteps = 0;
            m_locked = 0; m_c28 = 0;
        end else begin
            cur = eff(n - 3);
            prv = eff(n - 4);
            e_phase = pidx(cur);
            e_c14 = cur[1] ^ cur[0];
            qraw = n - m_tlast;
            vstep = (cur != prv) && (pnext(prv) == cur);
            istep = (cur != prv) && !vstep;
            if (vstep) begin
                meas = (qraw > 256) ? 256 : qraw;
                dq = meas - m_qper;
                if (dq < 0) dq = -dq;
                if (m_nsteps >= 2 && dq <= 2) begin
                    if (m_run < 8) m_run++;
                    if (m_run == 8) m_locked = 1;
                end else begin
                    m_run = 0; m_locked = 0;
                end
                m_qper = (qraw > 255) ? 255 : qraw;
                if (m_nsteps < 2) m_nsteps++;
                e_edge = 4'b0001 << e_phase;
                m_tlast = n;
            end else if (istep) begin
                e_err = 1; m_run = 0; m_locked = 0; m_tlast = n;
            end else begin
                qcnt = (qraw > 255) ? 255 : qraw;
                if (qcnt == 255) begin
                    m_run = 0; m_locked = 0;
                end
            end
            if (!m_locked) m_c28 = 0;
            else if (vstep) m_c28 = 1;
            else if (qcnt == m_qper / 2) m_c28 = 0;
            e_pre = m_locked && (m_qper > 2) && (qcnt + 2 == m_qper - 1);
        end
        chk("phase", PHASE, e_phase);
        chk("c14m", C14M_OUT, e_c14);
        chk("c28m", C28M_OUT, m_c28);
        chk("edge_stb", EDGE_STB, e_edge);
        chk("pre_stb", PRE_STB, e_pre);
        chk("locked", LOCKED, m_locked);
        chk("err_stb", ERR_STB, e_err);
        chk("qper", QPER, m_qper);
        o_edge = EDGE_STB; o_locked = LOCKED; o_err = ERR_STB;
        o_pre = PRE_STB; o_c28 = C28M_OUT; o_qper = QPER;
    endtask

    task automatic tick(input logic [1:0] v, input logic r);
        @(negedge CLK);
        model_step();
        if (n >= MAXN - 1) begin
            $display("FAIL history_overflow cycle=%0d got=%0d expected<%0d", n, n, MAXN);
            $fatal(1, "history overflow");
        end
        drv[n] = v;
        rstv[n] = r;
        {C7M, CDAC} = v;
        RESET = r;
        n++;
    endtask

    // Hold a state; report what was seen 3 cycles after it was applied.
    task automatic hold_state(input logic [1:0] v, input int hold, output logic [3:0] e3,
                              output logic l3, output logic [7:0] q3, output int errs);
        errs = 0; e3 = '0; l3 = 0; q3 = '0;
        for (int c = 0; c < hold; c++) begin
            tick(v, 1'b0);
            if (o_err) errs++;
            if (c == 3) begin
                e3 = o_edge; l3 = o_locked; q3 = o_qper;
            end
        end
    endtask

    initial begin
        vec_t       tbl [12];
        logic [1:0] cur_st;
        logic [3:0] e3;
        logic       l3;
        logic [7:0] q3;
        int         errs, edges, fall_c, pre_c, edge_c, c28_hi, hold, r;

        tbl[0]  = '{2'b01, 7, 4'b0010, 1'b0, 2'd1};
        tbl[1]  = '{2'b11, 7, 4'b0100, 1'b0, 2'd2};
        tbl[2]  = '{2'b10, 7, 4'b1000, 1'b0, 2'd3};
        tbl[3]  = '{2'b00, 7, 4'b0001, 1'b0, 2'd0};
        tbl[4]  = '{2'b01, 7, 4'b0010, 1'b0, 2'd1};
        tbl[5]  = '{2'b11, 7, 4'b0100, 1'b0, 2'd2};
        tbl[6]  = '{2'b10, 7, 4'b1000, 1'b0, 2'd3};
        tbl[7]  = '{2'b00, 7, 4'b0001, 1'b0, 2'd0};
        tbl[8]  = '{2'b01, 7, 4'b0010, 1'b0, 2'd1};
        tbl[9]  = '{2'b11, 7, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{2'b10, 7, 4'b1000, 1'b1, 2'd3};
        tbl[11] = '{2'b00, 7, 4'b0001, 1'b1, 2'd0};

        for (int j = 0; j < 4; j++) begin
            drv[j] = 2'b00;
            rstv[j] = 1'b1;
        end

        // Reset held for 4 cycles, then idle.
        for (int i = 0; i < 4; i++) tick(2'b00, 1'b1);
        chk("reset_phase", PHASE, 0);
        chk("reset_qper", QPER, 0);
        chk("reset_locked", LOCKED, 0);
        for (int i = 0; i < 5; i++) tick(2'b00, 1'b0);

        // Nominal 7-cycle quarters; lock on step 10.
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < tbl[i].hold; c++) begin
                tick(tbl[i].st, 1'b0);
                if (c == 3) begin
                    chk("tbl_edge", o_edge, tbl[i].exp_edge);
                    chk("tbl_locked", o_locked, tbl[i].exp_locked);
                    chk("tbl_phase", PHASE, tbl[i].exp_phase);
                    if (i >= 1) chk("tbl_qper", o_qper, 7);
                end
            end
        end
        cur_st = 2'b00;

        // Both inputs toggle together: one error, no edge, relock after 8 steps.
        cur_st = ~cur_st;
        hold_state(cur_st, 7, e3, l3, q3, errs);
        chk("illegal_err_count", errs, 1);
        chk("illegal_no_edge", e3, 0);
        chk("illegal_unlock", l3, 0);
        chk("illegal_qper_held", q3, 7);
        for (int i = 1; i <= 8; i++) begin
            cur_st = pnext(cur_st);
            hold_state(cur_st, 7, e3, l3, q3, errs);
            if (i == 7) chk("relock_not_yet", l3, 0);
            if (i == 8) chk("relock_after_8", l3, 1);
        end

        // Frozen clocks: LOCKED drops 255 cycles after the last edge strobe.
        cur_st = pnext(cur_st);
        fall_c = -1;
        for (int c = 0; c < 300; c++) begin
            tick(cur_st, 1'b0);
            if (fall_c < 0 && c > 3 && !o_locked) fall_c = c;
        end
        chk("timeout_fall_cycle", fall_c - 3, 255);
        chk("timeout_qper_held", o_qper, 7);
        for (int i = 1; i <= 10; i++) begin
            cur_st = pnext(cur_st);
            hold_state(cur_st, 7, e3, l3, q3, errs);
        end
        chk("relock_after_freeze", l3, 1);

        // Predictive strobe and C28M shape within one locked quarter.
        cur_st = pnext(cur_st);
        pre_c = -1; edge_c = -1; c28_hi = 0;
        for (int c = 0; c < 7; c++) begin
            tick(cur_st, 1'b0);
            if (o_pre) pre_c = c;
            if (o_edge != 0) edge_c = c;
            if (o_c28) c28_hi++;
            if (c == 3) chk("c28_high_at_step", o_c28, 1);
            if (c == 6) chk("c28_low_qcnt3", o_c28, 0);
        end
        chk("pre_position", pre_c, 0);
        chk("pre_to_edge_gap", edge_c - pre_c, 3);
        chk("c28_high_count", c28_hi, 3);

        // Stretched quarter of 10 cycles breaks lock and is measured.
        hold_state(cur_st, 3, e3, l3, q3, errs);
        cur_st = pnext(cur_st);
        hold_state(cur_st, 7, e3, l3, q3, errs);
        chk("stretch_unlock", l3, 0);
        chk("stretch_qper", q3, 10);
        for (int i = 1; i <= 10; i++) begin
            cur_st = pnext(cur_st);
            hold_state(cur_st, 7, e3, l3, q3, errs);
        end
        chk("locked_before_reset", l3, 1);
        tick(cur_st, 1'b1);
        tick(cur_st, 1'b0);
        chk("midreset_locked", o_locked, 0);
        chk("midreset_qper", o_qper, 0);

        // Randomized streams: mostly forward, some illegal/backward/odd lengths.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) cur_st = ~cur_st;
            else if (r == 1) cur_st = pnext(pnext(pnext(cur_st)));
            else cur_st = pnext(cur_st);
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : $urandom_range(6, 8);
            for (int c = 0; c < hold; c++) tick(cur_st, (k == 75 && c == 0) ? 1'b1 : 1'b0);
        end
        for (int c = 0; c < 8; c++) tick(cur_st, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
